operand_fetch32: RTL and testbench
==================================

# operand_fetch32

Operand-fetch pipeline stage that sits directly upstream of the 32 x 32 register file. It drives the register file's read selects from decoded instruction fields and captures the two read buses into a valid/ready pipeline register for the execute stage. A 32-entry pending-write scoreboard stalls read-after-write and write-after-write hazards against results not yet written back. Retirement is observed on the same write port (`wb_en`/`wb_sel`/`wb_data`) that feeds the register file's `wen`/`wsel`/`in`.

## Interface
- No parameters; the datapath is fixed at 32 bits and 32 registers.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: the decoder presents an instruction.
- `in_ready` output 1: the stage accepts the instruction this cycle.
- `in_ra`, `in_rb`, `in_rd` input 5 each: source A, source B and destination register numbers.
- `in_use_a`, `in_use_b`, `in_wr` input 1 each: source A read, source B read and destination write enables.
- `in_imm` input 32: immediate, passed through.
- `asel`, `bsel` output 5 each: combinational copies of `in_ra` and `in_rb`, driving the register file read selects.
- `rf_a`, `rf_b` input 32 each: register file read data for `asel` and `bsel`; combinational in the same cycle.
- `wb_en`, `wb_sel` input 1 / 5: write-back strobe and target, shared with the register file's `wen`/`wsel`.
- `wb_data` input 32: write-back data, shared with the register file's `in`.
- `flush` input 1: discard the contents of the output register.
- `out_valid` output 1: a fetched instruction is valid toward execute.
- `out_ready` input 1: execute consumes the instruction.
- `out_a`, `out_b`, `out_imm` output 32 each: operands and immediate.
- `out_rd` output 5, `out_wr` output 1: destination register and write enable, carried forward.

## Operation
- **Scoreboard.** `pending[31:0]` holds one bit per register. R0 is tracked like any other register.
- **Hazard terms.**
  - `raw_a = in_use_a & pending[in_ra] & ~byp_a`, where `byp_a = wb_en & (wb_sel == in_ra)` when bypass is enabled and 0 otherwise.
  - `raw_b` is the same expression using `in_rb` / `byp_b`.
  - `waw = in_wr & pending[in_rd]`. Bypass never relieves WAW.
- **Accept condition.** `in_ready = ~reset & ~raw_a & ~raw_b & ~waw & (~out_valid | out_ready)`. The term `issue = in_valid & in_ready`.
- **On issue:**
  - Load `out_a`, which is `wb_data` if `byp_a` else `rf_a`. Load `out_b` the same way.
  - Load `out_imm`, `out_rd`, `out_wr` from the inputs and set `out_valid = 1`.
  - If `in_wr`, set `pending[in_rd]`.
- **On consume** (`out_valid & out_ready & ~issue`): clear `out_valid`. Data outputs hold their last values.
- **On write-back** (`wb_en`): clear `pending[wb_sel]`.
  - Setting and clearing the same index in one cycle cannot occur, because WAW stalls any issue whose `in_rd` is pending.
  - A write-back to a register that is not pending is harmless.
- **On flush:**
  - Clear `out_valid`.
  - If the held instruction had `out_wr = 1`, clear `pending[out_rd]`; it will never write back.
  - Flush has priority over issue: `in_ready = 0` while `flush = 1`.
- **Reset state:** `pending = 0`, `out_valid = 0`, and `out_a`, `out_b`, `out_imm`, `out_rd`, `out_wr` all 0.

## Timing
- Latency is one cycle: an instruction issued at edge N appears on the `out_*` ports after edge N.
- Throughput is one instruction per cycle when there are no hazards and `out_ready = 1`.
- Read path: `asel`/`bsel` → register file → `rf_a`/`rf_b` → output register within one cycle.
- A write-back at edge N is visible through `rf_*` at cycle N+1.
- Without bypass, a RAW-dependent instruction issues no earlier than the cycle after `wb_en`. With bypass, it issues in the same cycle as `wb_en`.
- Back-pressure: with `out_valid = 1` and `out_ready = 0`, all `out_*` signals hold and `in_ready = 0`.
- Mid-operation reset: on the next edge everything returns to the reset state. In-flight pending bits are discarded, and write-backs arriving during reset are ignored.

## Configuration
- `OF_BYPASS_EN` defined:
  - A same-cycle write-back that matches a pending source supplies `wb_data` as the operand and suppresses the RAW stall.
  - When both sources match, both bypass.
- `OF_BYPASS_EN` undefined:
  - `byp_a` and `byp_b` are tied to 0; operands always come from `rf_a`/`rf_b`.
  - RAW costs at least one extra stall cycle.

## Test plan
- **Reset:** reset for 2 cycles with `in_valid = 1` → `in_ready = 0`, `out_valid = 0`, all outputs 0, scoreboard empty.
- **Basic fetch:** R3 = 0x3333 and R8 = 0x8888 preloaded; issue ra=3, rb=8, rd=5, imm=0x10 → next cycle `out_a = 0x3333`, `out_b = 0x8888`, `out_imm = 0x10`, `out_rd = 5`, `pending[5] = 1`.
- **RAW stall:** issue rd=9 write, then ra=9 → `in_ready = 0` until write-back.
  - With `wb_sel = 9`, `wb_data = 0x5A5A` and `OF_BYPASS_EN` defined: issue in the same cycle, `out_a = 0x5A5A`.
  - Without the macro: issue one cycle later, `out_a = 0x5A5A` via `rf_a`.
- **WAW stall:** issue rd=27 twice → the second stalls until `wb_en` with `wb_sel = 27`, then issues and re-sets `pending[27]`.
- **Back-pressure:** `out_ready = 0` for 3 cycles → outputs stable, `in_ready = 0`; `out_ready = 1` → next instruction issues that cycle.
- **Flush:** issue rd=31 and assert `flush` while it is held → `out_valid = 0` and `pending[31] = 0`; a following ra=31 reader issues without stall.

Source files
------------

// File: rtl/operand_fetch32.sv
// Operand-fetch stage: drives register file read selects, captures operands into a
// valid/ready output register, and stalls RAW/WAW hazards via a pending-write scoreboard.
// Optional same-cycle write-back bypass is enabled by defining OF_BYPASS_EN.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both high;
// in_ready never depends on in_valid, and out_* hold while out_valid & ~out_ready.
module operand_fetch32 (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_ra,
   input  logic [4:0]  in_rb,
   input  logic [4:0]  in_rd,
   input  logic        in_use_a,
   input  logic        in_use_b,
   input  logic        in_wr,
   input  logic [31:0] in_imm,
   output logic [4:0]  asel,
   output logic [4:0]  bsel,
   input  logic [31:0] rf_a,
   input  logic [31:0] rf_b,
   input  logic        wb_en,
   input  logic [4:0]  wb_sel,
   input  logic [31:0] wb_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [31:0] out_imm,
   output logic [4:0]  out_rd,
   output logic        out_wr,
   output logic [31:0] pending
);

   logic        byp_a, byp_b;
   logic        raw_a, raw_b, waw;
   logic        issue;
   logic [31:0] pending_nxt;
   logic [31:0] opnd_a, opnd_b;

   assign asel = in_ra;
   assign bsel = in_rb;

`ifdef OF_BYPASS_EN
   assign byp_a = wb_en & (wb_sel == in_ra);
   assign byp_b = wb_en & (wb_sel == in_rb);
`else
   logic unused_wb_data;
   assign unused_wb_data = ^wb_data;
   assign byp_a = 1'b0;
   assign byp_b = 1'b0;
`endif

   assign raw_a = in_use_a & pending[in_ra] & ~byp_a;
   assign raw_b = in_use_b & pending[in_rb] & ~byp_b;
   // Bypass never helps WAW: the older write must retire before the newer one is tracked.
   assign waw   = in_wr & pending[in_rd];

   assign in_ready = ~reset & ~flush & ~raw_a & ~raw_b & ~waw & (~out_valid | out_ready);
   assign issue    = in_valid & in_ready;

   assign opnd_a = byp_a ? wb_data : rf_a;
   assign opnd_b = byp_b ? wb_data : rf_b;

   // Set after clears is safe: WAW stalls any issue whose destination is still pending.
   always_comb begin
      pending_nxt = pending;
      if (wb_en)
         pending_nxt[wb_sel] = 1'b0;
      if (flush & out_valid & out_wr)
         pending_nxt[out_rd] = 1'b0;
      if (issue & in_wr)
         pending_nxt[in_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending   <= 32'd0;
         out_valid <= 1'b0;
         out_a     <= 32'd0;
         out_b     <= 32'd0;
         out_imm   <= 32'd0;
         out_rd    <= 5'd0;
         out_wr    <= 1'b0;
      end else begin
         pending <= pending_nxt;
         if (flush)
            out_valid <= 1'b0;
         else if (issue)
            out_valid <= 1'b1;
         else if (out_ready)
            out_valid <= 1'b0;
         if (issue) begin
            out_a   <= opnd_a;
            out_b   <= opnd_b;
            out_imm <= in_imm;
            out_rd  <= in_rd;
            out_wr  <= in_wr;
         end
      end
   end

endmodule

// File: tb/tb_operand_fetch32.sv
// Directed testbench for operand_fetch32 with a behavioural 32x32 register file;
// expectations follow OF_BYPASS_EN the same way as the design.
module tb_operand_fetch32;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_ra, in_rb, in_rd;
   logic        in_use_a, in_use_b, in_wr;
   logic [31:0] in_imm;
   logic [4:0]  asel, bsel;
   logic [31:0] rf_a, rf_b;
   logic        wb_en;
   logic [4:0]  wb_sel;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a, out_b, out_imm;
   logic [4:0]  out_rd;
   logic        out_wr;
   logic [31:0] pending;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] regs [32];

   always #5 clk = ~clk;

   // Register file model sharing the write-back port with the DUT.
   always @(posedge clk) begin
      if (wb_en)
         regs[wb_sel] <= wb_data;
   end
   assign rf_a = regs[asel];
   assign rf_b = regs[bsel];

   operand_fetch32 dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd),
      .in_use_a(in_use_a), .in_use_b(in_use_b), .in_wr(in_wr),
      .in_imm(in_imm), .asel(asel), .bsel(bsel),
      .rf_a(rf_a), .rf_b(rf_b),
      .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
      .out_rd(out_rd), .out_wr(out_wr), .pending(pending)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just past the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_ra = 5'd0; in_rb = 5'd0; in_rd = 5'd0;
      in_use_a = 1'b0; in_use_b = 1'b0; in_wr = 1'b0; in_imm = 32'd0;
   endtask

   task automatic present(input logic [4:0] ra, input logic ua, input logic [4:0] rb,
                          input logic ub, input logic [4:0] rd, input logic wr,
                          input logic [31:0] imm);
      in_valid = 1'b1; in_ra = ra; in_use_a = ua; in_rb = rb; in_use_b = ub;
      in_rd = rd; in_wr = wr; in_imm = imm;
   endtask

   task automatic writeback(input logic [4:0] sel, input logic [31:0] data);
      wb_en = 1'b1; wb_sel = sel; wb_data = data;
      tick();
      wb_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
   end

   initial begin
      idle();
      wb_en = 1'b0; wb_sel = 5'd0; wb_data = 32'd0;
      flush = 1'b0; out_ready = 1'b1;

      // Reset with a pending-looking instruction offered.
      reset = 1'b1;
      present(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 32'hFFFF);
      tick();
      tick();
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_a", out_a, 32'd0);
      check("rst_out_b", out_b, 32'd0);
      check("rst_out_imm", out_imm, 32'd0);
      check("rst_out_rd_wr", {26'd0, out_wr, out_rd}, 32'd0);
      check("rst_pending", pending, 32'd0);
      idle();
      reset = 1'b0;
      tick();

      // Preload R3/R8 through the shared write port (not pending: harmless).
      writeback(5'd3, 32'h3333);
      writeback(5'd8, 32'h8888);
      check("preload_pending", pending, 32'd0);

      // Basic fetch.
      present(5'd3, 1'b1, 5'd8, 1'b1, 5'd5, 1'b1, 32'h10);
      #1;
      check("fetch_in_ready", {31'd0, in_ready}, 32'd1);
      check("fetch_sel", {22'd0, asel, bsel}, {22'd0, 5'd3, 5'd8});
      tick();
      idle();
      check("fetch_out_valid", {31'd0, out_valid}, 32'd1);
      check("fetch_out_a", out_a, 32'h3333);
      check("fetch_out_b", out_b, 32'h8888);
      check("fetch_out_imm", out_imm, 32'h10);
      check("fetch_out_rd_wr", {26'd0, out_wr, out_rd}, {26'd0, 1'b1, 5'd5});
      check("fetch_pending", pending, 32'h0000_0020);
      writeback(5'd5, 32'h55);
      check("consume_out_valid", {31'd0, out_valid}, 32'd0);
      check("wb5_pending", pending, 32'd0);

      // RAW on R9.
      present(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 32'h9);
      tick();
      present(5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0, 32'h99);
      #1;
      check("raw_stall0", {31'd0, in_ready}, 32'd0);
      tick();
      check("raw_stall1", {31'd0, in_ready}, 32'd0);
      wb_en = 1'b1; wb_sel = 5'd9; wb_data = 32'h5A5A;
      #1;
`ifdef OF_BYPASS_EN
      check("raw_byp_ready", {31'd0, in_ready}, 32'd1);
      tick();
      wb_en = 1'b0;
      idle();
`else
      check("raw_nobyp_wait", {31'd0, in_ready}, 32'd0);
      tick();
      wb_en = 1'b0;
      #1;
      check("raw_nobyp_ready", {31'd0, in_ready}, 32'd1);
      tick();
      idle();
`endif
      check("raw_out_valid", {31'd0, out_valid}, 32'd1);
      check("raw_out_a", out_a, 32'h5A5A);
      check("raw_out_imm", out_imm, 32'h99);
      check("raw_pending", pending, 32'd0);
      tick();

      // WAW on R27.
      present(5'd0, 1'b0, 5'd0, 1'b0, 5'd27, 1'b1, 32'h27);
      tick();
      present(5'd0, 1'b0, 5'd0, 1'b0, 5'd27, 1'b1, 32'h2727);
      #1;
      check("waw_stall0", {31'd0, in_ready}, 32'd0);
      tick();
      check("waw_stall1", {31'd0, in_ready}, 32'd0);
      wb_en = 1'b1; wb_sel = 5'd27; wb_data = 32'h1;
      #1;
      check("waw_stall_wb", {31'd0, in_ready}, 32'd0);
      tick();
      wb_en = 1'b0;
      #1;
      check("waw_ready", {31'd0, in_ready}, 32'd1);
      tick();
      idle();
      check("waw_out_imm", out_imm, 32'h2727);
      check("waw_pending", pending, 32'h0800_0000);
      writeback(5'd27, 32'h2);
      check("waw_cleared", pending, 32'd0);

      // Back-pressure.
      out_ready = 1'b0;
      present(5'd3, 1'b1, 5'd8, 1'b1, 5'd1, 1'b0, 32'hAAAA);
      tick();
      present(5'd8, 1'b1, 5'd3, 1'b1, 5'd2, 1'b0, 32'hBBBB);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_out_imm", out_imm, 32'hAAAA);
         check("bp_out_a", out_a, 32'h3333);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", {31'd0, in_ready}, 32'd1);
      tick();
      idle();
      check("bp_next_imm", out_imm, 32'hBBBB);
      check("bp_next_a", out_a, 32'h8888);
      check("bp_next_b", out_b, 32'h3333);
      tick();

      // Flush of a held writer to R31.
      out_ready = 1'b0;
      present(5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 32'h31);
      tick();
      idle();
      check("fl_pending_set", pending, 32'h8000_0000);
      check("fl_held", {31'd0, out_valid}, 32'd1);
      flush = 1'b1;
      present(5'd31, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h3131);
      #1;
      check("fl_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      flush = 1'b0;
      #1;
      check("fl_out_valid", {31'd0, out_valid}, 32'd0);
      check("fl_pending_clr", pending, 32'd0);
      check("fl_reader_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      tick();
      idle();
      check("fl_reader_issued", {31'd0, out_valid}, 32'd1);
      check("fl_reader_imm", out_imm, 32'h3131);

      // Mid-operation reset drops in-flight state.
      present(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 32'h44);
      tick();
      idle();
      check("mid_pending_set", pending, 32'h0000_0010);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_pending", pending, 32'd0);
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_imm", out_imm, 32'd0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
